// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one 32-bit word-wide VRAM port between two tile layers,
// a sprite fetcher and a byte/nibble-addressed CPU port.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   l0_*/l1_*/spr_*              word read requests (req/addr in, ack/rddata_valid out)
//   cpu_*                        byte-address CPU port with byte and nibble writes
//   rddata                       read data shared by the layer/sprite ports
//   bus_*                        RAM side; RAM returns read data one cycle after the address
//
// Fixed priority l0 > l1 > spr > cpu. A CPU that has lost CPU_MAXWAIT times
// in a row wins outright. Grants, acks and the bus are combinational in the
// grant cycle; read return is steered one cycle later by a registered owner.
module vram_arbiter #(
  parameter int unsigned CPU_MAXWAIT = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        l0_req,
  input  logic [14:0] l0_addr,
  output logic        l0_ack,
  output logic        l0_rddata_valid,

  input  logic        l1_req,
  input  logic [14:0] l1_addr,
  output logic        l1_ack,
  output logic        l1_rddata_valid,

  input  logic        spr_req,
  input  logic [14:0] spr_addr,
  output logic        spr_ack,
  output logic        spr_rddata_valid,

  output logic [31:0] rddata,

  input  logic        cpu_req,
  input  logic [16:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wrdata,
  input  logic        cpu_nibble,
  input  logic        cpu_nibble_hi,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rddata,
  output logic        cpu_rddata_valid,

  output logic [14:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic [7:0]  bus_wrnibblesel,
  output logic        bus_write,
  input  logic [31:0] bus_rddata
);

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 8;

  typedef enum logic [1:0] {
    OWN_L0  = 2'd0,
    OWN_L1  = 2'd1,
    OWN_SPR = 2'd2,
    OWN_CPU = 2'd3
  } owner_e;

  owner_e          gnt_owner;
  logic            gnt_valid;
  logic            cpu_force;
  logic [1:0]      cpu_lane;

  logic [1:0]      wait_cnt;
  logic [1:0]      wait_cnt_d;

  owner_e          own_q;
  logic            own_valid_q;
  logic [1:0]      lane_q;
  logic [AW-1:0]   addr_q;
  logic            rd_valid;

  assign cpu_lane = cpu_addr[1:0];

  // Arbitration: starved CPU first, then fixed priority; nothing while in reset
  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = OWN_L0;
    cpu_force = cpu_req && (32'(wait_cnt) >= CPU_MAXWAIT);
    if (!rst) begin
      if (cpu_force) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_CPU;
      end else if (l0_req) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_L0;
      end else if (l1_req) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_L1;
      end else if (spr_req) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_SPR;
      end else if (cpu_req) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_CPU;
      end
    end
  end

  assign l0_ack  = gnt_valid && (gnt_owner == OWN_L0);
  assign l1_ack  = gnt_valid && (gnt_owner == OWN_L1);
  assign spr_ack = gnt_valid && (gnt_owner == OWN_SPR);
  assign cpu_ack = gnt_valid && (gnt_owner == OWN_CPU);

  // Bus drive from the granted request; address holds its last value when idle
  always_comb begin
    bus_addr        = rst ? '0 : addr_q;
    bus_write       = 1'b0;
    bus_wrnibblesel = '0;
    bus_wrdata      = '0;
    if (gnt_valid) begin
      unique case (gnt_owner)
        OWN_L0:  bus_addr = l0_addr;
        OWN_L1:  bus_addr = l1_addr;
        OWN_SPR: bus_addr = spr_addr;
        OWN_CPU: begin
          bus_addr = cpu_addr[16:2];
          if (cpu_write) begin
            bus_write = 1'b1;
            if (cpu_nibble) begin
              // nibble index within the word is {lane, hi}
              bus_wrdata = {NW{cpu_wrdata[3:0]}};
              bus_wrnibblesel[{cpu_lane, cpu_nibble_hi}] = 1'b1;
            end else begin
              bus_wrdata = {(DW/8){cpu_wrdata}};
              bus_wrnibblesel[{cpu_lane, 1'b0}] = 1'b1;
              bus_wrnibblesel[{cpu_lane, 1'b1}] = 1'b1;
            end
          end
        end
        default: bus_addr = addr_q;
      endcase
    end
  end

  // CPU wait counter: counts lost cycles, saturates, clears on grant or drop
  always_comb begin
    wait_cnt_d = wait_cnt;
    if (!cpu_req || cpu_ack) begin
      wait_cnt_d = 2'd0;
    end else if (wait_cnt != 2'd3) begin
      wait_cnt_d = wait_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 2'd0;
    end else begin
      wait_cnt <= wait_cnt_d;
    end
  end

  // Read-return ownership; writes leave no pending return
  always_ff @(posedge clk) begin
    if (rst) begin
      own_valid_q <= 1'b0;
      own_q       <= OWN_L0;
      lane_q      <= 2'd0;
      addr_q      <= '0;
    end else begin
      own_valid_q <= gnt_valid && !bus_write;
      addr_q      <= bus_addr;
      if (gnt_valid) begin
        own_q  <= gnt_owner;
        lane_q <= (gnt_owner == OWN_CPU) ? cpu_lane : 2'd0;
      end
    end
  end

  // A reset landing in the return cycle kills the pending valid
  assign rd_valid = own_valid_q && !rst;

  assign l0_rddata_valid  = rd_valid && (own_q == OWN_L0);
  assign l1_rddata_valid  = rd_valid && (own_q == OWN_L1);
  assign spr_rddata_valid = rd_valid && (own_q == OWN_SPR);
  assign cpu_rddata_valid = rd_valid && (own_q == OWN_CPU);

  assign rddata     = rd_valid ? bus_rddata : '0;
  assign cpu_rddata = rd_valid ? bus_rddata[{lane_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1); reset is synchronous and active-high, sampled on the rising edge of `clk`.
REQ-002 SHALL have parameter CPU_MAXWAIT, default 3, giving the number of cycles the CPU request may lose arbitration before it is forced to win.
REQ-003 SHALL have `l0_req`, `l1_req`, `spr_req` (in, 1 each): 32-bit word read requests from layer 0, layer 1 and the sprite fetcher.
REQ-004 SHALL have `l0_addr`, `l1_addr`, `spr_addr` (in, 15 each): word addresses.
REQ-005 SHALL have `l0_ack`, `l1_ack`, `spr_ack` (out, 1 each): the request was accepted this cycle.
REQ-006 SHALL have `l0_rddata_valid`, `l1_rddata_valid`, `spr_rddata_valid` (out, 1 each), sharing `rddata` (out, 32).
REQ-007 SHALL have `cpu_req` (in, 1), `cpu_addr` (in, 17, byte address), `cpu_write` (in, 1), `cpu_wrdata` (in, 8), `cpu_nibble` (in, 1, 4-bit write), `cpu_nibble_hi` (in, 1, selects the upper nibble).
REQ-008 SHALL have `cpu_ack` (out, 1), `cpu_rddata` (out, 8), `cpu_rddata_valid` (out, 1).
REQ-009 SHALL have the RAM-side ports `bus_addr` (out, 15), `bus_wrdata` (out, 32), `bus_wrnibblesel` (out, 8), `bus_write` (out, 1) and `bus_rddata` (in, 32); the RAM has 1-cycle registered read latency.

Function
REQ-010 SHALL grant at most one requester per cycle. Fixed priority is l0 > l1 > spr > cpu, except as overridden by REQ-011.
REQ-011 SHALL keep a 2-bit CPU wait counter:
- increments each cycle `cpu_req`=1 and the CPU is not granted, saturating at 3;
- clears on a CPU grant, and whenever `cpu_req`=0;
- when the counter is >= CPU_MAXWAIT and `cpu_req`=1, the CPU wins over all other requesters.
REQ-012 SHALL drive the bus combinationally from the granted request in the same cycle; the matching ack is high for exactly that cycle.
REQ-013 Requesters SHALL hold req and addr stable until ack. Dropping req before ack is allowed, and that request is then ignored.
REQ-014 Layer and sprite grants SHALL set `bus_write`=0, `bus_wrnibblesel`=0 and `bus_addr` to the requester's address.
REQ-015 A CPU grant SHALL map addresses as: `bus_addr`=`cpu_addr`[16:2], lane L=`cpu_addr`[1:0].
REQ-016 A CPU byte write SHALL:
- replicate `cpu_wrdata` into all four bytes of `bus_wrdata`;
- set `bus_wrnibblesel`[2L+1:2L]=2'b11, all other bits 0;
- set `bus_write`=1.
REQ-017 A CPU nibble write (`cpu_nibble`=1) SHALL:
- replicate `cpu_wrdata`[3:0] into all eight nibbles;
- set only `bus_wrnibblesel`[2L+`cpu_nibble_hi`].
REQ-018 A CPU read SHALL set `bus_write`=0 and `bus_wrnibblesel`=0.
REQ-019 SHALL register the grant owner (2 bits plus a valid flag) and lane L. In the cycle after any read grant, it SHALL:
- assert exactly that owner's rddata_valid for one cycle;
- drive `rddata`=`bus_rddata`;
- drive `cpu_rddata`=`bus_rddata`[8L+7:8L].
REQ-020 CPU writes SHALL produce no `cpu_rddata_valid`.
REQ-021 With no request pending, SHALL set `bus_write`=0 and `bus_wrnibblesel`=0. `bus_addr` holds its last value (registered hold) so idle reads are harmless.
REQ-022 Back-to-back grants every cycle SHALL be supported, giving one rddata_valid per cycle with correct ownership.
REQ-023 Simultaneous events:
- a new grant and the previous grant's rddata_valid occur in the same cycle without conflict;
- the CPU is never granted twice for one request.

Reset
REQ-024 While `rst`=1, SHALL hold all acks, all rddata_valid outputs, `bus_write` and `bus_wrnibblesel` at 0, `bus_addr`=0, `rddata`=0, `cpu_rddata`=0, the wait counter at 0 and the grant-valid flag at 0.
REQ-025 Reset asserted in the cycle after a read grant SHALL suppress that rddata_valid. No stale valid SHALL appear after reset release.
REQ-026 The first cycle after reset release SHALL arbitrate normally.

Verification
REQ-027 Write then read byte:
- `cpu_req`=1, `cpu_write`=1, `cpu_addr`=0x00006, `cpu_wrdata`=0xA5 -> `bus_addr`=1, `bus_wrnibblesel`=0x30, `bus_wrdata`=0xA5A5A5A5, `cpu_ack` for 1 cycle;
- then reading 0x00006 -> `cpu_rddata`=0xA5 one cycle after `cpu_ack`.
REQ-028 Nibble write:
- `cpu_addr`=0x00001, `cpu_nibble`=1, `cpu_nibble_hi`=1, `cpu_wrdata`=0x7 -> `bus_wrnibblesel`=0x08, `bus_wrdata`=0x77777777.
REQ-029 Priority:
- `l0_req`, `l1_req`, `spr_req` all held for 4 cycles -> acks in order l0, l1, spr;
- rddata_valid for each owner follows one cycle after its ack, with `rddata` equal to the RAM model's contents.
REQ-030 Starvation: `l0_req` and `cpu_req` held continuously -> `cpu_ack` in cycle 4 (after 3 losses), then the counter restarts.
REQ-031 Reset mid-read: `rst` pulsed in the cycle after an `l1_ack` -> `l1_rddata_valid` stays 0 and all outputs are at their reset values.
